// File: rtl/md_ctrl.sv
// md_ctrl: multiply/divide controller for the five-stage MIPS pipeline.
//
// Accepts mult/multu/div/divu/mthi/mtlo from the E stage, latches operands,
// holds busy for a fixed number of cycles and then commits the result into
// the HI/LO registers.
//
// Ports:
//   clk     in   1   system clock, rising-edge
//   reset   in   1   synchronous, active-high
//   E_mdop  in   3   0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 none
//   E_A     in  32   rs operand (multiplicand / dividend / mthi-mtlo source)
//   E_B     in  32   rt operand (multiplier / divisor)
//   start   out  1   combinational: multi-cycle op issued while idle
//   busy    out  1   registered: multi-cycle op in progress
//   HI      out 32   HI register
//   LO      out 32   LO register
module md_ctrl #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [2:0]  E_mdop,
   input  logic [31:0] E_A,
   input  logic [31:0] E_B,
   output logic        start,
   output logic        busy,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int unsigned CNT_W   = (MAX_CYC < 2) ? 1 : $clog2(MAX_CYC);

   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   typedef enum logic [1:0] {
      IDLE,
      MUL,
      DIV
   } state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q,   cnt_d;
   logic               busy_q,  busy_d;
   logic               sgn_q,   sgn_d;
   logic [31:0]        a_q,     a_d;
   logic [31:0]        b_q,     b_d;
   logic [31:0]        hi_q,    hi_d;
   logic [31:0]        lo_q,    lo_d;

   // Arithmetic on the latched operands only.
   logic signed [63:0] prod_s;
   logic [63:0]        prod_u;
   logic [31:0]        abs_a, abs_b, div_b;
   logic [31:0]        q_mag, r_mag;
   logic [31:0]        quot, rem;
   logic               neg_a, neg_b;

   always_comb begin
      prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
      prod_u = {32'd0, a_q} * {32'd0, b_q};

      // Signed divide is done on magnitudes; the 0x80000000 / -1 case falls
      // out naturally as 0x80000000 with zero remainder.
      neg_a = sgn_q & a_q[31];
      neg_b = sgn_q & b_q[31];
      abs_a = neg_a ? (~a_q + 32'd1) : a_q;
      abs_b = neg_b ? (~b_q + 32'd1) : b_q;
      // Divide-by-zero never commits; substitute 1 to keep the divider defined.
      div_b = (abs_b == '0) ? 32'd1 : abs_b;
      q_mag = abs_a / div_b;
      r_mag = abs_a % div_b;
      quot  = (neg_a ^ neg_b) ? (~q_mag + 32'd1) : q_mag;
      rem   = neg_a ? (~r_mag + 32'd1) : r_mag;
   end

   assign start = (state_q == IDLE) &&
                  ((E_mdop == OP_MULT) || (E_mdop == OP_MULTU) ||
                   (E_mdop == OP_DIV)  || (E_mdop == OP_DIVU));

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      sgn_d   = sgn_q;
      a_d     = a_q;
      b_d     = b_q;
      hi_d    = hi_q;
      lo_d    = lo_q;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               a_d    = E_A;
               b_d    = E_B;
               sgn_d  = (E_mdop == OP_MULT) || (E_mdop == OP_DIV);
               busy_d = 1'b1;
               if ((E_mdop == OP_MULT) || (E_mdop == OP_MULTU)) begin
                  cnt_d   = CNT_W'(MULT_CYCLES - 1);
                  state_d = MUL;
               end else begin
                  cnt_d   = CNT_W'(DIV_CYCLES - 1);
                  state_d = DIV;
               end
            end else if (E_mdop == OP_MTHI) begin
               hi_d = E_A;
            end else if (E_mdop == OP_MTLO) begin
               lo_d = E_A;
            end
         end

         MUL: begin
            if (cnt_q == '0) begin
               {hi_d, lo_d} = sgn_q ? prod_s : prod_u;
               busy_d  = 1'b0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end

         DIV: begin
            if (cnt_q == '0) begin
               if (b_q != '0) begin
                  hi_d = rem;
                  lo_d = quot;
               end
               busy_d  = 1'b0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end

         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         sgn_q   <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         sgn_q   <= sgn_d;
         a_q     <= a_d;
         b_q     <= b_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   assign busy = busy_q;
   assign HI   = hi_q;
   assign LO   = lo_q;

endmodule

// File: tb/tb_md_ctrl.sv
// tb_md_ctrl: directed bench for md_ctrl with a HI/LO result scoreboard.
module tb_md_ctrl;

   localparam int unsigned MC = 5;
   localparam int unsigned DC = 10;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  E_mdop;
   logic [31:0] E_A, E_B;
   logic        start, busy;
   logic [31:0] HI, LO;

   int tests = 0;
   int fails = 0;

   logic [63:0] sb_q[$];
   logic [31:0] hi_m, lo_m;

   md_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .clk    (clk),
      .reset  (reset),
      .E_mdop (E_mdop),
      .E_A    (E_A),
      .E_B    (E_B),
      .start  (start),
      .busy   (busy),
      .HI     (HI),
      .LO     (LO)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Enter the next cycle (inputs are driven here).
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Sample point inside the current cycle.
   task automatic smp();
      @(negedge clk);
   endtask

   function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [31:0] hi,
                                         input logic [31:0] lo);
      longint          ps;
      longint unsigned pu;
      int              sa, sb;
      sa = a;
      sb = b;
      case (op)
         3'd1: begin ps = longint'(sa) * longint'(sb); return ps; end
         3'd2: begin pu = {32'd0, a} * {32'd0, b}; return pu; end
         3'd3: begin
            if (b == 32'd0) return {hi, lo};
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
            return {32'(sa % sb), 32'(sa / sb)};
         end
         3'd4: begin
            if (b == 32'd0) return {hi, lo};
            return {a % b, a / b};
         end
         3'd5: return {a, lo};
         3'd6: return {hi, a};
         default: return {hi, lo};
      endcase
   endfunction

   // Multi-cycle op; optionally hold a second op with new operands while busy.
   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit hold, input logic [31:0] ha, input logic [31:0] hb);
      logic [63:0] exp;
      int unsigned n;
      n = (op <= 3'd2) ? MC : DC;
      cyc();
      E_mdop = op; E_A = a; E_B = b;
      smp();
      chk("start_c0", 32'(start), 32'd1);
      chk("busy_c0", 32'(busy), 32'd0);
      exp = model(op, a, b, hi_m, lo_m);
      sb_q.push_back(exp);
      {hi_m, lo_m} = exp;
      for (int unsigned i = 1; i <= n; i++) begin
         cyc();
         if (hold) begin
            E_mdop = 3'd1; E_A = ha; E_B = hb;
         end else begin
            E_mdop = 3'd0; E_A = $urandom; E_B = $urandom;
         end
         smp();
         chk("busy_win", 32'(busy), 32'd1);
         chk("start_busy", 32'(start), 32'd0);
      end
      cyc();
      E_mdop = 3'd0;
      smp();
      chk("busy_end", 32'(busy), 32'd0);
      exp = sb_q.pop_front();
      chk("hi_res", HI, exp[63:32]);
      chk("lo_res", LO, exp[31:0]);
   endtask

   task automatic mt_op(input logic [2:0] op, input logic [31:0] a);
      logic [63:0] exp;
      cyc();
      E_mdop = op; E_A = a; E_B = 32'd0;
      smp();
      chk("mt_start", 32'(start), 32'd0);
      exp = model(op, a, 32'd0, hi_m, lo_m);
      sb_q.push_back(exp);
      {hi_m, lo_m} = exp;
      cyc();
      E_mdop = 3'd0;
      smp();
      chk("mt_busy", 32'(busy), 32'd0);
      exp = sb_q.pop_front();
      chk("mt_hi", HI, exp[63:32]);
      chk("mt_lo", LO, exp[31:0]);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; E_mdop = 3'd0; E_A = '0; E_B = '0;
      hi_m = '0; lo_m = '0;
      cyc();
      smp();
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_hi", HI, 32'd0);
      chk("rst_lo", LO, 32'd0);
      cyc();
      reset = 1'b0;

      run_op(3'd1, 32'hFFFF_FFFE, 32'd3, 1'b0, '0, '0);
      run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, '0, '0);
      run_op(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, '0, '0);
      mt_op(3'd5, 32'h11);
      mt_op(3'd6, 32'h22);
      run_op(3'd4, 32'd100, 32'd0, 1'b0, '0, '0);
      run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, '0, '0);
      run_op(3'd3, 32'd20, 32'hFFFF_FFFA, 1'b1, 32'd7, 32'd9);
      run_op(3'd4, 32'hFFFF_FFF0, 32'd7, 1'b0, '0, '0);
      cyc();
      E_mdop = 3'd7;
      smp();
      chk("op7_start", 32'(start), 32'd0);

      // Reset in busy cycle 3 aborts the sequence.
      cyc();
      E_mdop = 3'd1; E_A = 32'd5; E_B = 32'd6;
      smp();
      chk("abort_start", 32'(start), 32'd1);
      cyc();
      E_mdop = 3'd0;
      cyc();
      cyc();
      reset = 1'b1;
      smp();
      chk("abort_busy3", 32'(busy), 32'd1);
      cyc();
      reset = 1'b0;
      smp();
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_hi", HI, 32'd0);
      chk("abort_lo", LO, 32'd0);
      hi_m = '0; lo_m = '0;
      sb_q.delete();

      // Reset wins over a simultaneous start.
      cyc();
      reset = 1'b1; E_mdop = 3'd3; E_A = 32'd9; E_B = 32'd2;
      cyc();
      reset = 1'b0; E_mdop = 3'd0;
      smp();
      chk("rst_vs_start", 32'(busy), 32'd0);

      run_op(3'd1, 32'h1234_5678, 32'hFFFF_FF00, 1'b0, '0, '0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
